handle_arbiter: RTL and testbench
=================================

# handle_arbiter

Round-robin arbiter and sequencer that shares the single `handle_handler` command port between N_REQ requesters. It grants one requester at a time and drives that requester's op/address/data into `handle_handler` for exactly one cycle. It then waits for the handler's response and returns it to the granted requester. It also records which requester allocated each handle and rejects accesses to a handle owned by a different requester.

## Interface
- N_REQ, 4: number of requesters; requester index width RW = clog2(N_REQ).
- ADDR_WIDTH, `ADDR_WIDTH: address/data width, same as `handle_handler`.
- HNDL_WIDTH, `HNDL_WIDTH: handle-id field width; handle all-ones is the op-base slot.
- TIMEOUT, 15: maximum cycles spent waiting for a handler response.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_op  in  3*N_REQ  packed ops; slice i is `[3*i+:3]`; only `READ` and `WRITE` are legal.
- req_addr  in  ADDR_WIDTH*N_REQ  packed addresses.
- req_data  in  ADDR_WIDTH*N_REQ  packed write data.
- req_ready  out  N_REQ  one-hot acceptance; a request transfers when valid and ready are both high.
- rsp_valid  out  N_REQ  one-hot, single-cycle response strobe.
- rsp_op, rsp_addr, rsp_data  out  3 / ADDR_WIDTH / ADDR_WIDTH  response payload, shared by all requesters.
- rsp_err  out  1  response is a rejection or a timeout.
- hh_op, hh_addr, hh_data  out  3 / ADDR_WIDTH / ADDR_WIDTH  command to `handle_handler`.
- hh_o_op, hh_o_addr, hh_o_data  in  3 / ADDR_WIDTH / ADDR_WIDTH  response from `handle_handler`; `hh_o_op != 0` means the response is valid.

## Operation
- Address decode:
  - Handle region: addr[ADDR_WIDTH-1] = 1; handle field h = addr[ADDR_WIDTH-2 -: HNDL_WIDTH].
  - If h is not all-ones, the address is a data access to handle h.
  - If h is all-ones, the address is an op access; target handle = addr[HNDL_WIDTH-1:0]. Target all-ones is OP_BASE.
- Ownership table: one entry per handle 0 .. 2^HNDL_WIDTH-2, holding a valid bit and an RW-bit owner.
  - Allocate: a successful READ of OP_BASE whose response has hh_o_data[HNDL_WIDTH-1:0] != all-ones sets that entry to {1, granted requester}.
  - Free: a successful WRITE to the op address of handle h with data 0 clears entry h.
  - Reject: a data or op access to handle h, where entry h is valid and its owner is not the granted requester, is not issued downstream and returns rsp_err = 1.
  - Unowned handles and non-handle addresses are passed through unchecked.
- Illegal op (anything other than `READ`/`WRITE`): rejected, rsp_err = 1, nothing issued downstream.
- Round-robin arbitration: pointer rr, reset 0. Search order is rr, rr+1, … modulo N_REQ. After a grant to g, rr becomes (g+1) mod N_REQ.
- FSM states:
  - IDLE: if any req_valid is high, assert req_ready[g] for the selected g, latch g/op/addr/data, go to CHECK. Otherwise stay.
  - CHECK: decode the latched request and the owner table. Reject → RESP with err. Otherwise go to ISSUE.
  - ISSUE: hh_op/hh_addr/hh_data = latched values for this one cycle. If hh_o_op != 0, capture → RESP. Otherwise go to WAIT with timer = 1.
  - WAIT: hh_op = 0. If hh_o_op != 0, capture → RESP. Else if timer == TIMEOUT → RESP with err. Else timer++.
  - RESP: rsp_valid[g] = 1; rsp_op/rsp_addr/rsp_data = captured values (on rejection: latched op/addr, data 0). Apply the table update. Go to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, rr = 0, owner table cleared, timer 0.
- Reset asserted mid-transaction abandons the transaction; no rsp_valid is produced.
- req_ready is combinational from req_valid in IDLE. It is low in every other state.
- Only one transaction is outstanding at a time. The next acceptance happens in the IDLE cycle after RESP.
- Latency, counting the acceptance cycle as 0:
  - Response in the ISSUE cycle: rsp_valid in cycle 3.
  - Rejection: rsp_valid in cycle 2.
  - Timeout: rsp_valid in cycle TIMEOUT+3.
- hh_op is nonzero for exactly one cycle per issued request. hh_addr and hh_data are 0 whenever hh_op = 0.
- A response on hh_o_op in IDLE, CHECK or RESP is ignored.
- A request that drops req_valid while not granted is simply lost; no error is raised.
- Allocate and free apply at the RESP clock edge, so they are visible to the CHECK of the very next transaction.

## Test plan
- Single requester 0 READs OP_BASE; handler returns o_data = 2 → rsp_valid[0] in cycle 3 with rsp_data = 2 and rsp_err = 0; owner[2] = 0.
- Requesters 0–3 all valid continuously from reset → grant order 0, 1, 2, 3, 0. Exactly one hh_op pulse per grant.
- Requester 0 owns handle 2; requester 1 READs H_ADDR(2,5) → no hh_op pulse; rsp_valid[1] in cycle 2 with rsp_err = 1. The same access from requester 0 passes through.
- Requester 0 WRITEs H_OP(2) with data 0 → owner[2] cleared. Requester 1 then accesses H_ADDR(2,1) → forwarded, rsp_err = 0.
- Handler never responds with TIMEOUT = 15 → rsp_valid at cycle 18 with rsp_err = 1. The FSM then returns to IDLE and accepts the next request.
- rst asserted during WAIT → all outputs 0 immediately and no rsp_valid. After release the owner table is empty and rr = 0.

Source files
------------

// File: rtl/handle_arbiter_if.sv
// Bundle of the requester-side and handler-side signals of handle_arbiter.
// Valid/ready: a request transfers on a rising clk edge where req_valid[i]
// and req_ready[i] are both high; req_ready is one-hot and never waits on
// anything but req_valid. Responses are single-cycle strobes on rsp_valid
// with no back-pressure. Towards the handler, a nonzero op is the strobe in
// both directions.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

interface handle_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  logic [N_REQ-1:0]            req_valid;
  logic [3*N_REQ-1:0]          req_op;
  logic [ADDR_WIDTH*N_REQ-1:0] req_addr;
  logic [ADDR_WIDTH*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [2:0]                  rsp_op;
  logic [ADDR_WIDTH-1:0]       rsp_addr;
  logic [ADDR_WIDTH-1:0]       rsp_data;
  logic                        rsp_err;
  logic [2:0]                  hh_op;
  logic [ADDR_WIDTH-1:0]       hh_addr;
  logic [ADDR_WIDTH-1:0]       hh_data;
  logic [2:0]                  hh_o_op;
  logic [ADDR_WIDTH-1:0]       hh_o_addr;
  logic [ADDR_WIDTH-1:0]       hh_o_data;
  logic [2:0]                  dbg_state;

  // Requesters plus the handle_handler side.
  modport master (
    output req_valid, req_op, req_addr, req_data, hh_o_op, hh_o_addr, hh_o_data,
    input  req_ready, rsp_valid, rsp_op, rsp_addr, rsp_data, rsp_err,
    input  hh_op, hh_addr, hh_data, dbg_state
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_op, req_addr, req_data, hh_o_op, hh_o_addr, hh_o_data,
    output req_ready, rsp_valid, rsp_op, rsp_addr, rsp_data, rsp_err,
    output hh_op, hh_addr, hh_data, dbg_state
  );
endinterface

// File: rtl/handle_arbiter.sv
// Round-robin arbiter/sequencer sharing the handle_handler command port.
// One transaction in flight at a time; an ownership table records which
// requester allocated each handle and blocks accesses from other requesters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef HNDL_WIDTH
`define HNDL_WIDTH 4
`endif

module handle_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int HNDL_WIDTH = `HNDL_WIDTH,
  parameter int TIMEOUT    = 15
) (
  input  logic            clk,
  input  logic            rst,
  handle_arbiter_if.slave bus
);
  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = ADDR_WIDTH;
  localparam int HW = HNDL_WIDTH;
  localparam int NH = 1 << HW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    OP_READ  = 3'd1;
  localparam logic [2:0]    OP_WRITE = 3'd2;
  localparam logic [HW-1:0] H_ONES   = '1;
  localparam logic [RW-1:0] LAST     = RW'(N_REQ - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [RW-1:0] rr_q, rr_d, gnt_q, gnt_d;
  logic [2:0]    op_q, op_d, cap_op_q, cap_op_d;
  logic [AW-1:0] addr_q, addr_d, data_q, data_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d, cap_data_q, cap_data_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  // The all-ones entry is never written; it only keeps the index in range.
  logic [NH-1:0]         own_vld_q, own_vld_d;
  logic [NH-1:0][RW-1:0] own_id_q, own_id_d;

  logic [N_REQ-1:0] req_ready, rsp_valid;
  logic [2:0]       rsp_op, hh_op;
  logic [AW-1:0]    rsp_addr, rsp_data, hh_addr, hh_data;
  logic             rsp_err;
  logic [RW-1:0]    pick;

  // First valid requester at or after rr, wrapping.
  function automatic logic [RW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [RW-1:0] start);
    logic [RW-1:0] idx, sel;
    logic          found;
    sel   = '0;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + RW'(1);
    end
    return sel;
  endfunction

  assign pick = rr_pick(bus.req_valid, rr_q);

  // Address decode of the latched request.
  logic          is_hndl, op_acc, chk_own, illegal, reject, do_alloc, do_free;
  logic [HW-1:0] fld, tgt, new_h;
  assign is_hndl  = addr_q[AW-1];
  assign fld      = addr_q[AW-2 -: HW];
  assign op_acc   = (fld == H_ONES);
  assign tgt      = op_acc ? addr_q[HW-1:0] : fld;
  assign chk_own  = is_hndl && (tgt != H_ONES);
  assign illegal  = (op_q != OP_READ) && (op_q != OP_WRITE);
  assign reject   = illegal || (chk_own && own_vld_q[tgt] && (own_id_q[tgt] != gnt_q));
  assign new_h    = cap_data_q[HW-1:0];
  assign do_alloc = !err_q && (op_q == OP_READ) && is_hndl && op_acc &&
                    (tgt == H_ONES) && (new_h != H_ONES);
  assign do_free  = !err_q && (op_q == OP_WRITE) && is_hndl && op_acc &&
                    (tgt != H_ONES) && (data_q == '0);

  // Next-state, datapath capture and output decode of the sequencer.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cap_op_d   = cap_op_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    err_d      = err_q;
    timer_d    = timer_q;
    own_vld_d  = own_vld_q;
    own_id_d   = own_id_q;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_op     = '0;
    rsp_addr   = '0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    hh_op      = '0;
    hh_addr    = '0;
    hh_data    = '0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          // Held low during reset so nothing is handed over while flops are cleared.
          req_ready[pick] = ~rst;
          gnt_d   = pick;
          op_d    = bus.req_op[3*int'(pick) +: 3];
          addr_d  = bus.req_addr[AW*int'(pick) +: AW];
          data_d  = bus.req_data[AW*int'(pick) +: AW];
          rr_d    = (pick == LAST) ? '0 : pick + RW'(1);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject) begin
          err_d      = 1'b1;
          cap_op_d   = op_q;
          cap_addr_d = addr_q;
          cap_data_d = '0;
          state_d    = S_RESP;
        end else begin
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        hh_op   = op_q;
        hh_addr = addr_q;
        hh_data = data_q;
        if (bus.hh_o_op != '0) begin
          cap_op_d   = bus.hh_o_op;
          cap_addr_d = bus.hh_o_addr;
          cap_data_d = bus.hh_o_data;
          state_d    = S_RESP;
        end else begin
          timer_d = TW'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.hh_o_op != '0) begin
          cap_op_d   = bus.hh_o_op;
          cap_addr_d = bus.hh_o_addr;
          cap_data_d = bus.hh_o_data;
          state_d    = S_RESP;
        end else if (timer_q == T_MAX) begin
          // Timeout reports the request itself with no data.
          err_d      = 1'b1;
          cap_op_d   = op_q;
          cap_addr_d = addr_q;
          cap_data_d = '0;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_op   = cap_op_q;
        rsp_addr = cap_addr_q;
        rsp_data = cap_data_q;
        rsp_err  = err_q;
        if (do_alloc) begin
          own_vld_d[new_h] = 1'b1;
          own_id_d[new_h]  = gnt_q;
        end
        if (do_free) begin
          own_vld_d[tgt] = 1'b0;
        end
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request, captured response and ownership table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cap_op_q   <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      own_vld_q  <= '0;
      own_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cap_op_q   <= cap_op_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      own_vld_q  <= own_vld_d;
      own_id_q   <= own_id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_op    = rsp_op;
  assign bus.rsp_addr  = rsp_addr;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.hh_op     = hh_op;
  assign bus.hh_addr   = hh_addr;
  assign bus.hh_data   = hh_data;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_handle_arbiter.sv
// Bench for handle_arbiter: behavioural handle_handler, scoreboard of
// expected responses with latency and downstream pulse counts.
module tb_handle_arbiter;
  localparam logic [2:0] RD = 3'd1;
  localparam logic [2:0] WR = 3'd2;
  localparam int W = 38;  // {idx[1:0], op[2:0], addr[15:0], data[15:0], err}

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   rsp_cnt;
  int   pulse_cnt;
  int   idle_bad;
  int   hh_mode;  // 0: same-cycle reply, 1: two-cycle delayed reply, 2: silent
  logic [15:0] alloc_id;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           iss_q[$];
  int           acc_q[$];

  logic [2:0]  d1_op, d2_op;
  logic [15:0] d1_addr, d2_addr, d1_data, d2_data;

  handle_arbiter_if #(.N_REQ(4), .ADDR_WIDTH(16)) bus ();

  handle_arbiter #(
    .N_REQ(4), .ADDR_WIDTH(16), .HNDL_WIDTH(4), .TIMEOUT(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- handler model ----------------
  function automatic logic [15:0] hh_reply(input logic [2:0] op, input logic [15:0] addr,
                                           input logic [15:0] data, input logic [15:0] aid);
    if (op == RD && addr == 16'hF80F) return aid;
    if (op == RD) return addr ^ 16'h5a5a;
    return data;
  endfunction

  always @(posedge clk) begin
    d1_op   <= bus.hh_op;
    d1_addr <= bus.hh_addr;
    d1_data <= hh_reply(bus.hh_op, bus.hh_addr, bus.hh_data, alloc_id);
    d2_op   <= d1_op;
    d2_addr <= d1_addr;
    d2_data <= d1_data;
  end

  always_comb begin
    bus.hh_o_op   = '0;
    bus.hh_o_addr = '0;
    bus.hh_o_data = '0;
    if (hh_mode == 0) begin
      bus.hh_o_op   = bus.hh_op;
      bus.hh_o_addr = bus.hh_addr;
      bus.hh_o_data = hh_reply(bus.hh_op, bus.hh_addr, bus.hh_data, alloc_id);
    end else if (hh_mode == 1) begin
      bus.hh_o_op   = d2_op;
      bus.hh_o_addr = d2_addr;
      bus.hh_o_data = d2_data;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] addr,
                         input logic [15:0] data);
    bus.req_op[3*i +: 3]    = op;
    bus.req_addr[16*i +: 16] = addr;
    bus.req_data[16*i +: 16] = data;
  endtask

  task automatic exp_push(input int i, input logic [2:0] op, input logic [15:0] addr,
                          input logic [15:0] data, input logic err, input int lat, input int iss);
    exp_q.push_back({2'(i), op, addr, data, err});
    lat_q.push_back(lat);
    iss_q.push_back(iss);
  endtask

  // Raise the masked valids, drop them all after n acceptances, await n responses.
  task automatic burst(input logic [3:0] mask, input int n);
    int acc;
    int target;
    acc    = 0;
    target = rsp_cnt + n;
    @(posedge clk);
    #1 bus.req_valid = mask;
    for (int c = 0; c < 200 && acc < n; c++) begin
      @(negedge clk);
      if (|(bus.req_valid & bus.req_ready)) acc++;
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    check("accepts", 64'(acc), 64'(n));
    for (int c = 0; c < 100 && rsp_cnt < target; c++) @(negedge clk);
    check("responses", 64'(rsp_cnt), 64'(target));
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [W-1:0] obs;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.hh_op != '0) pulse_cnt++;
        else if (bus.hh_addr != '0 || bus.hh_data != '0) idle_bad++;
        if (|(bus.req_valid & bus.req_ready)) acc_q.push_back(cyc);
        if (bus.rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("rsp_spurious", 64'(bus.rsp_valid), 64'd0);
          end else begin
            obs = {oh2idx(bus.rsp_valid), bus.rsp_op, bus.rsp_addr, bus.rsp_data, bus.rsp_err};
            check("rsp_onehot", 64'($onehot(bus.rsp_valid)), 64'd1);
            check("rsp_payload", 64'(obs), 64'(exp_q.pop_front()));
            lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
            check("rsp_latency", 64'(lat), 64'(lat_q.pop_front()));
            check("hh_pulses", 64'(pulse_cnt), 64'(iss_q.pop_front()));
          end
          pulse_cnt = 0;
          rsp_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    cyc = 0; total = 0; bad = 0; rsp_cnt = 0; pulse_cnt = 0; idle_bad = 0;
    hh_mode = 0; alloc_id = 16'd0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_op, bus.rsp_addr, bus.rsp_data}), 64'd0);
    check("rst_hh", 64'({bus.hh_op, bus.hh_addr, bus.hh_data, bus.req_ready}), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four contend: round-robin order 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_req(i, RD, 16'h0100 + 16'(i), 16'h1000 + 16'(i));
    exp_push(0, RD, 16'h0100, 16'h0100 ^ 16'h5a5a, 1'b0, 3, 1);
    exp_push(1, RD, 16'h0101, 16'h0101 ^ 16'h5a5a, 1'b0, 3, 1);
    exp_push(2, RD, 16'h0102, 16'h0102 ^ 16'h5a5a, 1'b0, 3, 1);
    exp_push(3, RD, 16'h0103, 16'h0103 ^ 16'h5a5a, 1'b0, 3, 1);
    exp_push(0, RD, 16'h0100, 16'h0100 ^ 16'h5a5a, 1'b0, 3, 1);
    burst(4'hF, 5);

    // Requester 0 allocates handle 2.
    alloc_id = 16'd2;
    set_req(0, RD, 16'hF80F, 16'h0);
    exp_push(0, RD, 16'hF80F, 16'd2, 1'b0, 3, 1);
    burst(4'b0001, 1);

    // Requester 1 touches handle 2: rejected, nothing issued.
    set_req(1, RD, 16'h9005, 16'h0);
    exp_push(1, RD, 16'h9005, 16'h0, 1'b1, 2, 0);
    burst(4'b0010, 1);

    // Owner passes through.
    set_req(0, RD, 16'h9005, 16'h0);
    exp_push(0, RD, 16'h9005, 16'h9005 ^ 16'h5a5a, 1'b0, 3, 1);
    burst(4'b0001, 1);

    // Owner frees handle 2, then requester 1 may use it.
    set_req(0, WR, 16'hF802, 16'h0);
    exp_push(0, WR, 16'hF802, 16'h0, 1'b0, 3, 1);
    burst(4'b0001, 1);
    set_req(1, RD, 16'h9001, 16'h0);
    exp_push(1, RD, 16'h9001, 16'h9001 ^ 16'h5a5a, 1'b0, 3, 1);
    burst(4'b0010, 1);

    // Illegal op.
    set_req(3, 3'd5, 16'h0200, 16'h7777);
    exp_push(3, 3'd5, 16'h0200, 16'h0, 1'b1, 2, 0);
    burst(4'b1000, 1);

    // Handler answers from WAIT after two cycles.
    hh_mode = 1;
    set_req(2, WR, 16'h0400, 16'h1234);
    exp_push(2, WR, 16'h0400, 16'h1234, 1'b0, 5, 1);
    burst(4'b0100, 1);

    // Handler silent: timeout, then normal service resumes.
    hh_mode = 2;
    set_req(2, RD, 16'h0300, 16'h0);
    exp_push(2, RD, 16'h0300, 16'h0, 1'b1, 18, 1);
    burst(4'b0100, 1);
    hh_mode = 0;
    set_req(3, RD, 16'h0700, 16'h0);
    exp_push(3, RD, 16'h0700, 16'h0700 ^ 16'h5a5a, 1'b0, 3, 1);
    burst(4'b1000, 1);

    // Re-own handle 2, then abandon a transaction from 2 by reset during WAIT.
    set_req(0, RD, 16'hF80F, 16'h0);
    exp_push(0, RD, 16'hF80F, 16'd2, 1'b0, 3, 1);
    burst(4'b0001, 1);
    hh_mode = 2;
    set_req(2, RD, 16'h0500, 16'h0);
    @(posedge clk);
    #1 bus.req_valid = 4'b0100;
    for (int c = 0; c < 10 && !bus.req_ready[2]; c++) @(negedge clk);
    check("inflight_accept", 64'(bus.req_ready[2]), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (5) @(posedge clk);
    #1 check("inflight_wait", 64'(bus.dbg_state), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("midrst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_op, bus.rsp_addr, bus.rsp_data}), 64'd0);
    check("midrst_hh", 64'({bus.hh_op, bus.hh_addr, bus.hh_data, bus.req_ready}), 64'd0);
    check("midrst_state", 64'(bus.dbg_state), 64'd0);
    exp_q.delete(); lat_q.delete(); iss_q.delete(); acc_q.delete();
    pulse_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hh_mode = 0;
    repeat (5) @(posedge clk);

    // rr back at 0: with 0 and 3 pending, 0 goes first.
    set_req(0, RD, 16'h0600, 16'h0);
    set_req(3, RD, 16'h0603, 16'h0);
    exp_push(0, RD, 16'h0600, 16'h0600 ^ 16'h5a5a, 1'b0, 3, 1);
    exp_push(3, RD, 16'h0603, 16'h0603 ^ 16'h5a5a, 1'b0, 3, 1);
    burst(4'b1001, 2);

    // Ownership forgotten across reset.
    a = 16'h9001;
    set_req(1, RD, a, 16'h0);
    exp_push(1, RD, a, a ^ 16'h5a5a, 1'b0, 3, 1);
    burst(4'b0010, 1);

    repeat (3) @(posedge clk);
    check("hh_idle_zero", 64'(idle_bad), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
